// File: rtl/lsu_pkg.sv
// Shared definitions for the dm_lsu load/store unit: size codes, FSM encoding
// and the decode helpers used to classify a request at accept time.
package lsu_pkg;

  localparam logic [2:0] DIG_W  = 3'b000;
  localparam logic [2:0] DIG_H  = 3'b001;
  localparam logic [2:0] DIG_B  = 3'b010;
  localparam logic [2:0] DIG_HU = 3'b101;
  localparam logic [2:0] DIG_BU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic digit_legal(input logic [2:0] digit);
    case (digit)
      DIG_W, DIG_H, DIG_B, DIG_HU, DIG_BU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Misaligned halves and words are broken into byte beats.
  function automatic logic [2:0] beat_count(input logic [2:0] digit,
                                            input logic [1:0] addr_lo);
    case (digit)
      DIG_W:         return (addr_lo == 2'b00) ? 3'd1 : 3'd4;
      DIG_H, DIG_HU: return addr_lo[0] ? 3'd2 : 3'd1;
      default:       return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the load assembly register, selected by the size code.
// Re-extending a value that dm already extended leaves it unchanged.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        digit,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = din;
    case (digit)
      DIG_H:   dout = {{(DATA_W-16){din[15]}}, din[15:0]};
      DIG_HU:  dout = {{(DATA_W-16){1'b0}}, din[15:0]};
      DIG_B:   dout = {{(DATA_W-8){din[7]}}, din[7:0]};
      DIG_BU:  dout = {{(DATA_W-8){1'b0}}, din[7:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: accepts one request at a time and drives it to dm either
// as a single native beat or, when misaligned, as a sequence of byte beats.
module dm_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  // Request: accepted on req_valid & req_ready; response is a single-cycle pulse.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_digit,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic [2:0]        dm_digit,
  input  logic [DATA_W-1:0] dm_dout,
  output logic [1:0]        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        digit_q, digit_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              err_q, err_d;

  logic [2:0]        n_beats;
  logic              split;
  logic              last_beat;
  logic [DATA_W-1:0] ext_rdata;

  assign n_beats   = beat_count(digit_q, addr_q[1:0]);
  assign split     = (n_beats != 3'd1);
  assign last_beat = ({1'b0, beat_cnt_q} == 3'(n_beats - 3'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      digit_q    <= DIG_W;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      digit_q    <= digit_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    digit_d    = digit_q;
    asm_d      = asm_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          digit_d    = req_digit;
          asm_d      = '0;
          beat_cnt_d = 2'd0;
          err_d      = !digit_legal(req_digit);
          state_d    = digit_legal(req_digit) ? ST_BEAT : ST_RESP;
        end
      end
      ST_BEAT: begin
        if (split) asm_d[8*beat_cnt_q +: 8] = dm_dout[7:0];
        else       asm_d = dm_dout;
        if (last_beat) state_d = ST_RESP;
        else           beat_cnt_d = beat_cnt_q + 2'd1;
      end
      ST_RESP: begin
        beat_cnt_d = 2'd0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_extend #(.DATA_W(DATA_W)) u_extend (
    .digit (digit_q),
    .din   (asm_q),
    .dout  (ext_rdata)
  );

  // dm_we comes only from registered state so reset drops it asynchronously.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
    resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? ext_rdata : '0;
    dm_we      = 1'b0;
    dm_addr    = addr_q;
    dm_din     = '0;
    dm_digit   = DIG_W;
    if (state_q == ST_BEAT) begin
      dm_we = we_q;
      if (split) begin
        dm_addr     = addr_q + ADDR_W'(beat_cnt_q);
        dm_digit    = we_q ? DIG_B : DIG_BU;
        dm_din[7:0] = wdata_q[8*beat_cnt_q +: 8];
      end else begin
        dm_digit = digit_q;
        dm_din   = wdata_q;
      end
    end
    dbg_state = state_q;
  end

endmodule
